spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync.sv | 27 ++
 rtl/spi_slave.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave.
// Every file in the block imports this package so data and synchronizer widths are defined once.
package spi_pkg;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int BIT_W       = $clog2(DATA_W);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin.
// The reset value is a parameter so each pin starts at its inactive level.
module spi_sync
    import spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    // NOTE: sequential state uses non-blocking assignments only, so stages shift one flop per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave for all four modes, clocked entirely by the system clock.
// spi_clk, cs_n and mosi are oversampled, and the block keeps one TX holding register.
module spi_slave
    import spi_pkg::*;
#(
    parameter int CLK_RATIO = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              spi_clk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int              FLUSH_W  = $clog2(SYNC_STAGES + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    // The synchronizer and edge-detect latency consumes several clk cycles of every spi_clk half period.
    if (CLK_RATIO < 8) begin : g_ratio_check
        $error("spi_slave: CLK_RATIO must be at least 8");
    end

    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;

    spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(spi_clk), .q(sclk_s));
    spi_sync #(.RESET_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs_n),    .q(cs_s));
    spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi),    .q(mosi_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    // A chip select that is already low when reset releases is not a frame start.
    // Arm only after the synchronizer has flushed and cs_n has been seen high.
    logic [FLUSH_W-1:0] flush_cnt;
    logic               cs_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
            cs_armed  <= 1'b0;
        end else begin
            if (flush_cnt != FLUSH_W'(SYNC_STAGES)) begin
                flush_cnt <= flush_cnt + FLUSH_W'(1);
            end
            if ((flush_cnt == FLUSH_W'(SYNC_STAGES)) && cs_s) begin
                cs_armed <= 1'b1;
            end
        end
    end

    state_t             state, state_next;
    logic               cpol_q, cpha_q;
    logic [BIT_W-1:0]   bit_cnt;
    logic               start_pending;
    logic [DATA_W-1:0]  rx_shift, rx_next;
    logic [DATA_W-1:0]  tx_shift, hold_data;
    logic               hold_full;

    logic cs_fall, cs_rise, sclk_edge, lead_edge, trail_edge;
    logic in_frame, sample_ev, shift_ev, enter;
    logic cont_start, byte_start, tx_shift_ev, handshake;

    assign cs_fall    = cs_d & ~cs_s;
    assign cs_rise    = ~cs_d & cs_s;
    assign sclk_edge  = sclk_s ^ sclk_d;
    assign lead_edge  = sclk_edge & (sclk_s ^ cpol_q);
    assign trail_edge = sclk_edge & ~(sclk_s ^ cpol_q);

    // Deselection wins over any spi_clk edge seen in the same cycle.
    assign in_frame   = (state == ACTIVE) & ~cs_rise;
    assign sample_ev  = in_frame & (cpha_q ? trail_edge : lead_edge);
    assign shift_ev   = in_frame & (cpha_q ? lead_edge : trail_edge);
    assign enter      = (state == IDLE) & cs_fall & cs_armed;

    // After a wrap, the next shift edge presents the MSB of the following byte, so the byte start
    // waits for that edge. A frame that ends on the wrap does not consume a held byte.
    assign cont_start  = shift_ev & (bit_cnt == '0) & start_pending;
    assign byte_start  = enter | cont_start;
    assign tx_shift_ev = shift_ev & (bit_cnt != '0);
    assign handshake   = tx_valid & tx_ready;
    assign rx_next     = {rx_shift[DATA_W-2:0], mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default first so every path assigns state_next and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enter)   state_next = ACTIVE;
            ACTIVE:  if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            bit_cnt       <= '0;
            start_pending <= 1'b0;
            rx_shift      <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            tx_shift      <= '0;
            hold_data     <= '0;
            hold_full     <= 1'b0;
            tx_underrun   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (enter) begin
                cpol_q        <= cpol;
                cpha_q        <= cpha;
                bit_cnt       <= '0;
                start_pending <= 1'b0;
            end

            // A partial byte is dropped; the held TX byte survives deselection.
            if ((state == ACTIVE) && cs_rise) begin
                bit_cnt       <= '0;
                start_pending <= 1'b0;
            end

            if (sample_ev) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + BIT_W'(1);
                if (bit_cnt == LAST_BIT) begin
                    rx_data       <= rx_next;
                    rx_valid      <= 1'b1;
                    start_pending <= 1'b1;
                end
            end

            if (cont_start) begin
                start_pending <= 1'b0;
            end

            if (byte_start) begin
                if (hold_full) begin
                    tx_shift  <= hold_data;
                    hold_full <= 1'b0;
                end else if (tx_valid) begin
                    tx_shift <= tx_data;
                end else begin
                    tx_shift    <= '1;
                    tx_underrun <= 1'b1;
                end
            end else begin
                if (tx_shift_ev) begin
                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b1};
                end
                if (handshake) begin
                    hold_data <= tx_data;
                    hold_full <= 1'b1;
                end
            end
        end
    end

    assign busy     = (state == ACTIVE);
    assign miso_oe  = busy;
    assign miso     = miso_oe & tx_shift[DATA_W-1];
    assign tx_ready = ~hold_full;

endmodule
